// File: rtl/kappa3_mem_if.sv
// Data-memory port bundle between the KAPPA3 controller (master) and the memory responder (slave).
interface kappa3_mem_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [3:0]  mem_wrbits;
    logic [31:0] wrdata;
    logic [31:0] rddata;
    logic        mem_ready;
    logic        mem_err;

    modport master (
        output mem_read, mem_write, addr, mem_wrbits, wrdata,
        input  rddata, mem_ready, mem_err
    );

    modport slave (
        input  mem_read, mem_write, addr, mem_wrbits, wrdata,
        output rddata, mem_ready, mem_err
    );
endinterface

// File: rtl/kappa3_data_mem.sv
// KAPPA3 data-memory responder: word RAM with programmable wait states and a one-cycle ready pulse.
// Optional store alignment checking is enabled by defining KAPPA3_MEM_ALIGN_CHECK_EN.
module kappa3_data_mem #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input logic        clock,
    input logic        reset,
    kappa3_mem_if.slave bus
);

    localparam int unsigned IDX_W = ADDR_WIDTH - 2;
    localparam int unsigned DEPTH = 1 << IDX_W;
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP,
        HOLD
    } state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [3:0]              lat_mask;
    logic [31:0]             lat_data;
    logic                    lat_write;

    logic [31:0]             ram [DEPTH];
    logic [31:0]             rddata_q;
    logic                    ready_q;
    logic                    err_q;

    logic                    req_c;
    logic                    access_c;
    logic [ADDR_WIDTH-1:0]   acc_addr_c;
    logic [3:0]              acc_mask_c;
    logic [31:0]             acc_data_c;
    logic                    acc_write_c;
    logic [IDX_W-1:0]        acc_idx_c;
    logic [31:0]             lane_data_c;
    logic                    legal_c;
    logic                    do_store_c;

    assign req_c = bus.mem_read | bus.mem_write;

    // With zero wait states the access happens on the accepting edge, so it uses the live inputs
    // (exactly the values being latched); otherwise it uses the latched copy.
    always_comb begin
        acc_addr_c  = lat_addr;
        acc_mask_c  = lat_mask;
        acc_data_c  = lat_data;
        acc_write_c = lat_write;
        access_c    = 1'b0;
        if (state == IDLE) begin
            acc_addr_c  = bus.addr[ADDR_WIDTH-1:0];
            acc_mask_c  = bus.mem_wrbits;
            acc_data_c  = bus.wrdata;
            acc_write_c = bus.mem_write;
            access_c    = req_c && (WAIT_CYCLES == 0);
        end else if (state == WAIT) begin
            access_c    = (cnt == 4'd0);
        end
    end

    assign acc_idx_c = acc_addr_c[ADDR_WIDTH-1:2];

    // Right-aligned store data is replicated so halves and bytes land on their selected lanes.
    always_comb begin
        lane_data_c = acc_data_c;
        case (acc_mask_c)
            4'b0011, 4'b1100:                   lane_data_c = {2{acc_data_c[15:0]}};
            4'b0001, 4'b0010, 4'b0100, 4'b1000: lane_data_c = {4{acc_data_c[7:0]}};
            default:                            lane_data_c = acc_data_c;
        endcase
    end

`ifdef KAPPA3_MEM_ALIGN_CHECK_EN
    always_comb begin
        legal_c = 1'b0;
        case (acc_mask_c)
            4'b1111: legal_c = (acc_addr_c[1:0] == 2'd0);
            4'b0011: legal_c = (acc_addr_c[1:0] == 2'd0);
            4'b1100: legal_c = (acc_addr_c[1:0] == 2'd2);
            4'b0001: legal_c = (acc_addr_c[1:0] == 2'd0);
            4'b0010: legal_c = (acc_addr_c[1:0] == 2'd1);
            4'b0100: legal_c = (acc_addr_c[1:0] == 2'd2);
            4'b1000: legal_c = (acc_addr_c[1:0] == 2'd3);
            default: legal_c = 1'b0;
        endcase
    end
`else
    logic unused_addr;
    assign legal_c     = 1'b1;
    assign unused_addr = ^acc_addr_c[1:0];
`endif

    logic unused_upper;
    assign unused_upper = ^bus.addr[31:ADDR_WIDTH];

    assign do_store_c = reset && access_c && acc_write_c && legal_c;

    // Byte-lane RAM; contents survive reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (do_store_c && acc_mask_c[i]) begin
                ram[acc_idx_c][8*i +: 8] <= lane_data_c[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_addr  <= '0;
            lat_mask  <= 4'd0;
            lat_data  <= 32'd0;
            lat_write <= 1'b0;
            rddata_q  <= 32'd0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_c) begin
                        lat_addr  <= bus.addr[ADDR_WIDTH-1:0];
                        lat_mask  <= bus.mem_wrbits;
                        lat_data  <= bus.wrdata;
                        lat_write <= bus.mem_write;
                        cnt       <= CNT_INIT;
                        state     <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: state <= HOLD;
                HOLD: begin
                    if (!req_c) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (access_c) begin
                ready_q <= 1'b1;
                err_q   <= acc_write_c & ~legal_c;
                if (!acc_write_c) begin
                    rddata_q <= ram[acc_idx_c];
                end
            end
        end
    end

    assign bus.rddata    = rddata_q;
    assign bus.mem_ready = ready_q;
    assign bus.mem_err   = err_q;

endmodule

// File: tb/tb_kappa3_data_mem.sv
// Directed bench for kappa3_data_mem with three instances at 0, 1 and 3 wait states.
module tb_kappa3_data_mem;

    logic clock = 1'b0;
    logic rst0, rst1, rst3;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    kappa3_mem_if if0 ();
    kappa3_mem_if if1 ();
    kappa3_mem_if if3 ();

    kappa3_data_mem #(.ADDR_WIDTH(12), .WAIT_CYCLES(0)) u0 (.clock(clock), .reset(rst0), .bus(if0.slave));
    kappa3_data_mem #(.ADDR_WIDTH(12), .WAIT_CYCLES(1)) u1 (.clock(clock), .reset(rst1), .bus(if1.slave));
    kappa3_data_mem #(.ADDR_WIDTH(12), .WAIT_CYCLES(3)) u3 (.clock(clock), .reset(rst3), .bus(if3.slave));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int sel, input logic rd, input logic wr, input logic [31:0] a,
                           input logic [3:0] m, input logic [31:0] d);
        case (sel)
            0: begin if0.mem_read = rd; if0.mem_write = wr; if0.addr = a; if0.mem_wrbits = m; if0.wrdata = d; end
            1: begin if1.mem_read = rd; if1.mem_write = wr; if1.addr = a; if1.mem_wrbits = m; if1.wrdata = d; end
            default: begin if3.mem_read = rd; if3.mem_write = wr; if3.addr = a; if3.mem_wrbits = m; if3.wrdata = d; end
        endcase
    endtask

    function automatic logic get_ready(input int sel);
        case (sel)
            0:       return if0.mem_ready;
            1:       return if1.mem_ready;
            default: return if3.mem_ready;
        endcase
    endfunction

    function automatic logic [31:0] get_rddata(input int sel);
        case (sel)
            0:       return if0.rddata;
            1:       return if1.rddata;
            default: return if3.rddata;
        endcase
    endfunction

    function automatic logic get_err(input int sel);
        case (sel)
            0:       return if0.mem_err;
            1:       return if1.mem_err;
            default: return if3.mem_err;
        endcase
    endfunction

    // Called at a negedge with the DUT idle; returns latency in edges, or -1 on timeout.
    task automatic do_op(input int sel, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [3:0] m, input logic [31:0] d,
                         output int lat, output logic [31:0] rdd, output logic err);
        lat = -1;
        rdd = 32'hxxxx_xxxx;
        err = 1'bx;
        set_req(sel, rd, wr, a, m, d);
        for (int i = 1; i <= 30; i++) begin
            @(posedge clock);
            #1;
            if (get_ready(sel)) begin
                lat = i;
                rdd = get_rddata(sel);
                err = get_err(sel);
                break;
            end
        end
        set_req(sel, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
    endtask

    int          lat;
    int          pulses;
    logic [31:0] rdd;
    logic        err;

    initial begin
        rst0 = 1'b0; rst1 = 1'b0; rst3 = 1'b0;
        set_req(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        set_req(1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        set_req(3, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        repeat (3) @(posedge clock);
        #1;
        check("rst_ready1", 32'(if1.mem_ready), 32'd0);
        check("rst_err1",   32'(if1.mem_err),   32'd0);
        check("rst_rddata1", if1.rddata,         32'd0);
        check("rst_ready0", 32'(if0.mem_ready), 32'd0);
        check("rst_rddata3", if3.rddata,         32'd0);
        @(negedge clock);
        rst0 = 1'b1; rst1 = 1'b1; rst3 = 1'b1;
        @(negedge clock);

        // Word store then load at one wait state.
        do_op(1, 1'b0, 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, lat, rdd, err);
        check("sw_lat1", 32'(lat), 32'd2);
        check("sw_err1", 32'(err), 32'd0);
        check("sw_rdd_unchanged", rdd, 32'd0);
        do_op(1, 1'b1, 1'b0, 32'h10, 4'b0000, 32'd0, lat, rdd, err);
        check("lw_lat1", 32'(lat), 32'd2);
        check("lw_data1", rdd, 32'hDEADBEEF);

        // Byte and half lanes.
        do_op(1, 1'b0, 1'b1, 32'h20, 4'b1111, 32'h00000000, lat, rdd, err);
        do_op(1, 1'b0, 1'b1, 32'h23, 4'b1000, 32'h000000AB, lat, rdd, err);
        check("sb_err", 32'(err), 32'd0);
        do_op(1, 1'b0, 1'b1, 32'h20, 4'b0011, 32'h00001234, lat, rdd, err);
        do_op(1, 1'b1, 1'b0, 32'h20, 4'b0000, 32'd0, lat, rdd, err);
        check("lanes_data", rdd, 32'hAB001234);

        // Zero wait states.
        do_op(0, 1'b0, 1'b1, 32'h08, 4'b1111, 32'h11223344, lat, rdd, err);
        check("sw_lat0", 32'(lat), 32'd1);
        do_op(0, 1'b1, 1'b0, 32'h08, 4'b0000, 32'd0, lat, rdd, err);
        check("lw_lat0", 32'(lat), 32'd1);
        check("lw_data0", rdd, 32'h11223344);

        // Three wait states.
        do_op(3, 1'b0, 1'b1, 32'h08, 4'b1111, 32'h55667788, lat, rdd, err);
        check("sw_lat3", 32'(lat), 32'd4);
        do_op(3, 1'b1, 1'b0, 32'h08, 4'b0000, 32'd0, lat, rdd, err);
        check("lw_lat3", 32'(lat), 32'd4);
        check("lw_data3", rdd, 32'h55667788);

        // Held request: exactly one pulse, then a fresh load is serviced.
        set_req(0, 1'b1, 1'b0, 32'h08, 4'b0000, 32'd0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            if (if0.mem_ready) pulses++;
        end
        check("hold_pulses0", 32'(pulses), 32'd1);
        set_req(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        @(posedge clock); @(posedge clock); @(negedge clock);
        do_op(0, 1'b1, 1'b0, 32'h08, 4'b0000, 32'd0, lat, rdd, err);
        check("after_hold_lat0", 32'(lat), 32'd1);
        check("after_hold_data0", rdd, 32'h11223344);

        set_req(3, 1'b1, 1'b0, 32'h08, 4'b0000, 32'd0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            if (if3.mem_ready) pulses++;
        end
        check("hold_pulses3", 32'(pulses), 32'd1);
        set_req(3, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        @(posedge clock); @(posedge clock); @(negedge clock);
        do_op(3, 1'b1, 1'b0, 32'h08, 4'b0000, 32'd0, lat, rdd, err);
        check("after_hold_lat3", 32'(lat), 32'd4);
        check("after_hold_data3", rdd, 32'h55667788);

        // Simultaneous read and write: write wins, rddata keeps the previous load.
        do_op(1, 1'b1, 1'b0, 32'h10, 4'b0000, 32'd0, lat, rdd, err);
        do_op(1, 1'b1, 1'b1, 32'h40, 4'b1111, 32'h5A5A5A5A, lat, rdd, err);
        check("both_lat", 32'(lat), 32'd2);
        check("both_rdd_unchanged", rdd, 32'hDEADBEEF);
        do_op(1, 1'b1, 1'b0, 32'h40, 4'b0000, 32'd0, lat, rdd, err);
        check("both_written", rdd, 32'h5A5A5A5A);

        // Reset during WAIT discards the store.
        do_op(3, 1'b0, 1'b1, 32'h50, 4'b1111, 32'hCAFEF00D, lat, rdd, err);
        do_op(3, 1'b1, 1'b0, 32'h50, 4'b0000, 32'd0, lat, rdd, err);
        check("old_word", rdd, 32'hCAFEF00D);
        set_req(3, 1'b0, 1'b1, 32'h50, 4'b1111, 32'h99999999);
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        rst3 = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            if (if3.mem_ready) pulses++;
        end
        check("rstw_pulses", 32'(pulses), 32'd0);
        check("rstw_ready", 32'(if3.mem_ready), 32'd0);
        check("rstw_err", 32'(if3.mem_err), 32'd0);
        check("rstw_rddata", if3.rddata, 32'd0);
        @(negedge clock);
        set_req(3, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        @(posedge clock);
        @(negedge clock);
        rst3 = 1'b1;
        @(posedge clock);
        @(negedge clock);
        do_op(3, 1'b1, 1'b0, 32'h1050, 4'b0000, 32'd0, lat, rdd, err);
        check("alias_lat", 32'(lat), 32'd4);
        check("alias_preserved", rdd, 32'hCAFEF00D);

        // Misaligned half store.
        do_op(1, 1'b0, 1'b1, 32'h60, 4'b1111, 32'h00000000, lat, rdd, err);
        do_op(1, 1'b0, 1'b1, 32'h62, 4'b0011, 32'h0000BEEF, lat, rdd, err);
        check("mis_lat", 32'(lat), 32'd2);
`ifdef KAPPA3_MEM_ALIGN_CHECK_EN
        check("mis_err", 32'(err), 32'd1);
`else
        check("mis_err", 32'(err), 32'd0);
`endif
        check("err_cleared", 32'(if1.mem_err), 32'd0);
        do_op(1, 1'b1, 1'b0, 32'h60, 4'b0000, 32'd0, lat, rdd, err);
        check("mis_load_err", 32'(err), 32'd0);
`ifdef KAPPA3_MEM_ALIGN_CHECK_EN
        check("mis_ram", rdd, 32'h00000000);
`else
        check("mis_ram", rdd, 32'h0000BEEF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
